// File: rtl/sprite_plotter.sv
// Sprite plotter: walks the sprite word store to erase the sprite at its old origin, then draws it at the new one.
// Optional macro SPRITE_TRANSPARENCY_EN makes colour 3'b111 words transparent in both passes.
module sprite_plotter #(
    parameter int         SPRITE_WORDS = 220,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] BG_COLOUR    = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  x_coord,
    input  logic [6:0]  y_coord,
    output logic [9:0]  word_addr,
    input  logic [15:0] word_in,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        writeEn,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_DRAW  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [9:0] LAST_ADDR = 10'(SPRITE_WORDS - 1);
    localparam logic [8:0] X_LIMIT   = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT   = 8'(SCREEN_H);

    state_t      state_q;
    logic [9:0]  addr_q;
    logic [7:0]  nx_q;
    logic [6:0]  ny_q;
    logic [7:0]  ox_q;
    logic [6:0]  oy_q;
    logic        have_old_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  colour_q;
    logic        we_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  base_x_d;
    logic [6:0]  base_y_d;
    logic [8:0]  sum_x_d;
    logic [7:0]  sum_y_d;
    logic [2:0]  pix_col_d;
    logic        pix_we_d;
    logic        reserved_unused;

    // Transparent words are skipped in both passes so the background under them is never touched.
    function automatic logic word_drawable(input logic [15:0] w);
`ifdef SPRITE_TRANSPARENCY_EN
        return w[0] && (w[5:3] != 3'b111);
`else
        return w[0];
`endif
    endfunction

    assign reserved_unused = ^word_in[2:1];

    // Pixel for the word currently addressed, placed at the origin of the active pass.
    always_comb begin
        base_x_d  = nx_q;
        base_y_d  = ny_q;
        pix_col_d = word_in[5:3];
        if (state_q == S_ERASE) begin
            base_x_d  = ox_q;
            base_y_d  = oy_q;
            pix_col_d = BG_COLOUR;
        end else begin
            base_x_d  = nx_q;
            base_y_d  = ny_q;
            pix_col_d = word_in[5:3];
        end
        // Widened sums keep off-screen pixels from wrapping back into view.
        sum_x_d  = {1'b0, base_x_d} + {4'b0000, word_in[15:11]};
        sum_y_d  = {1'b0, base_y_d} + {3'b000, word_in[10:6]};
        pix_we_d = word_drawable(word_in) && (sum_x_d < X_LIMIT) && (sum_y_d < Y_LIMIT);
    end

    // Redraw sequencer with registered pixel outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= 10'd0;
            nx_q       <= 8'd0;
            ny_q       <= 7'd0;
            ox_q       <= 8'd0;
            oy_q       <= 7'd0;
            have_old_q <= 1'b0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'd0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    we_q <= 1'b0;
                    if (start) begin
                        nx_q    <= x_coord;
                        ny_q    <= y_coord;
                        addr_q  <= 10'd0;
                        busy_q  <= 1'b1;
                        state_q <= have_old_q ? S_ERASE : S_DRAW;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_ERASE, S_DRAW: begin
                    x_q      <= sum_x_d[7:0];
                    y_q      <= sum_y_d[6:0];
                    colour_q <= pix_col_d;
                    we_q     <= pix_we_d;
                    if (addr_q == LAST_ADDR) begin
                        addr_q  <= 10'd0;
                        state_q <= (state_q == S_ERASE) ? S_DRAW : S_FLUSH;
                    end else begin
                        addr_q  <= addr_q + 10'd1;
                    end
                end
                S_FLUSH: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    we_q       <= 1'b0;
                    ox_q       <= nx_q;
                    oy_q       <= ny_q;
                    have_old_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    addr_q  <= 10'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign word_addr = addr_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign writeEn   = we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: table of redraws with hand-computed pixel writes, plus
// multi-cycle sequences for start-at-done, held start and reset in the middle of a DRAW pass.
module tb_sprite_plotter;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [7:0]  x_coord;
    logic [6:0]  y_coord;
    logic [9:0]  word_addr;
    logic [15:0] word_in;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       t;   // pixel comes from a colour-7 word
    } wr_t;

    typedef struct packed {
        logic [7:0] nx;
        logic [6:0] ny;
        logic       mset;
        logic       pulse;
        logic [9:0] cycles;
        logic [5:0] first;
        logic [5:0] cnt;
    } vec_t;

    wr_t  ew [26];
    vec_t vecs [5];
    wr_t  got [$];

    sprite_plotter dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .word_addr (word_addr),
        .word_in   (word_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy),
        .done      (done)
    );

    assign word_in = mem[word_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (writeEn) got.push_back('{x, y, colour, 1'b0});
    end

    function automatic logic [15:0] mkword(input logic [4:0] xo, input logic [4:0] yo,
                                           input logic [2:0] c, input logic v);
        return {xo, yo, c, 2'b00, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] nx, input logic [6:0] ny, input bit hold);
        @(negedge clock);
        got.delete();
        x_coord = nx;
        y_coord = ny;
        start   = 1'b1;
        @(negedge clock);
        if (!hold) start = 1'b0;
    endtask

    // Called at the negedge of cycle 'cyc'; returns with cyc = cycle in which done was seen.
    task automatic wait_done(input bit pulse, inout int cyc);
        while (!done && cyc < 3000) begin
            if (pulse && cyc == 50) begin
                start   = 1'b1;
                x_coord = 8'd5;
                y_coord = 7'd5;
            end else if (pulse && cyc == 51) begin
                start   = 1'b0;
            end else begin
                start   = start;
            end
            @(negedge clock);
            cyc++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end
    endtask

    task automatic check_writes(input string tag, input int first, input int cnt);
        wr_t exp_q [$];
        for (int k = first; k < first + cnt; k++) begin
            if (!(TRANSP && ew[k].t)) exp_q.push_back(ew[k]);
        end
        chk({tag, "_nwrites"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            chk($sformatf("%s_w%0d_xyc", tag, k), {14'd0, got[k].x, got[k].y, got[k].c},
                {14'd0, exp_q[k].x, exp_q[k].y, exp_q[k].c});
        end
    endtask

    initial begin
        int cyc;
        resetn  = 1'b0;
        start   = 1'b0;
        x_coord = 8'd0;
        y_coord = 7'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
        mem[5] = mkword(5'd3, 5'd4, 3'd4, 1'b1);

        ew[0]  = '{8'd13,  7'd24,  3'd4, 1'b0};
        ew[1]  = '{8'd13,  7'd24,  3'd0, 1'b0};
        ew[2]  = '{8'd53,  7'd64,  3'd4, 1'b0};
        ew[3]  = '{8'd53,  7'd64,  3'd0, 1'b0};
        ew[4]  = '{8'd62,  7'd72,  3'd0, 1'b0};
        ew[5]  = '{8'd59,  7'd69,  3'd0, 1'b0};
        ew[6]  = '{8'd50,  7'd60,  3'd0, 1'b1};
        ew[7]  = '{8'd81,  7'd91,  3'd0, 1'b0};
        ew[8]  = '{8'd153, 7'd114, 3'd4, 1'b0};
        ew[9]  = '{8'd159, 7'd119, 3'd1, 1'b0};
        ew[10] = '{8'd150, 7'd110, 3'd7, 1'b1};
        ew[11] = '{8'd153, 7'd114, 3'd0, 1'b0};
        ew[12] = '{8'd159, 7'd119, 3'd0, 1'b0};
        ew[13] = '{8'd150, 7'd110, 3'd0, 1'b1};
        ew[14] = '{8'd159, 7'd119, 3'd7, 1'b1};
        ew[15] = '{8'd159, 7'd119, 3'd0, 1'b1};
        ew[16] = '{8'd3,   7'd4,   3'd4, 1'b0};
        ew[17] = '{8'd12,  7'd12,  3'd2, 1'b0};
        ew[18] = '{8'd9,   7'd9,   3'd1, 1'b0};
        ew[19] = '{8'd0,   7'd0,   3'd7, 1'b1};
        ew[20] = '{8'd31,  7'd31,  3'd6, 1'b0};
        ew[21] = '{8'd13,  7'd24,  3'd4, 1'b0};
        ew[22] = '{8'd22,  7'd32,  3'd2, 1'b0};
        ew[23] = '{8'd19,  7'd29,  3'd1, 1'b0};
        ew[24] = '{8'd10,  7'd20,  3'd7, 1'b1};
        ew[25] = '{8'd41,  7'd51,  3'd6, 1'b0};

        vecs[0] = '{8'd10,  7'd20,  1'b0, 1'b0, 10'd222, 6'd0,  6'd1};
        vecs[1] = '{8'd50,  7'd60,  1'b0, 1'b1, 10'd442, 6'd1,  6'd2};
        vecs[2] = '{8'd150, 7'd110, 1'b1, 1'b0, 10'd442, 6'd3,  6'd8};
        vecs[3] = '{8'd159, 7'd119, 1'b1, 1'b0, 10'd442, 6'd11, 6'd4};
        vecs[4] = '{8'd0,   7'd0,   1'b1, 1'b0, 10'd442, 6'd15, 6'd6};

        repeat (3) @(negedge clock);
        chk("reset_outputs", {10'd0, word_addr, x, y, colour, writeEn, busy, done}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].mset) begin
                mem[7]   = mkword(5'd12, 5'd12, 3'd2, 1'b1);
                mem[9]   = mkword(5'd9,  5'd9,  3'd1, 1'b1);
                mem[11]  = mkword(5'd0,  5'd0,  3'd7, 1'b1);
                mem[12]  = mkword(5'd1,  5'd1,  3'd5, 1'b0);
                mem[219] = mkword(5'd31, 5'd31, 3'd6, 1'b1);
            end
            launch(vecs[i].nx, vecs[i].ny, 1'b0);
            cyc = 1;
            chk($sformatf("v%0d_busy_first", i), {31'd0, busy}, 32'd1);
            wait_done(vecs[i].pulse, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, {22'd0, vecs[i].cycles});
            chk($sformatf("v%0d_busy_in_done", i), {31'd0, busy}, 32'd1);
            check_writes($sformatf("v%0d", i), {26'd0, vecs[i].first}, {26'd0, vecs[i].cnt});
            @(negedge clock);
            chk($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
        end

        // start raised only during the DONE cycle is not taken
        launch(8'd20, 8'd30, 1'b0);
        cyc = 1;
        wait_done(1'b0, cyc);
        chk("h1_cycles", cyc, 32'd442);
        start   = 1'b1;
        x_coord = 8'd90;
        y_coord = 7'd90;
        @(negedge clock);
        start = 1'b0;
        chk("h1_idle", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("h1_start_at_done_ignored", {31'd0, busy}, 32'd0);

        // start held high restarts right after the IDLE cycle
        launch(8'd30, 7'd40, 1'b1);
        cyc = 1;
        wait_done(1'b0, cyc);
        chk("h2_cycles", cyc, 32'd442);
        @(negedge clock);
        chk("h2_idle_gap", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("h2_restart", {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc = 1;
        wait_done(1'b0, cyc);
        chk("h2_second_cycles", cyc, 32'd442);
        @(negedge clock);

        // reset in the middle of the DRAW pass, then a redraw without ERASE
        launch(8'd60, 7'd70, 1'b0);
        cyc = 1;
        while (cyc < 321) begin
            @(negedge clock);
            cyc++;
        end
        chk("h3_addr_mid_draw", {22'd0, word_addr}, 32'd100);
        resetn = 1'b0;
        @(negedge clock);
        chk("h3_reset_outputs", {10'd0, word_addr, x, y, colour, writeEn, busy, done}, 32'd0);
        resetn = 1'b1;
        launch(8'd10, 7'd20, 1'b0);
        cyc = 1;
        wait_done(1'b0, cyc);
        chk("h3_no_erase_cycles", cyc, 32'd222);
        check_writes("h3", 21, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Downstream stage of the sprite word store.
- Walks the sprite word memory once per frame update.
- Erases the sprite at its previous origin, then draws it at the new origin.
- Emits one clipped pixel write per cycle (x, y, colour, writeEn) to the 160x120, 3-bit-colour VGA adapter.

Parameters:
- SPRITE_WORDS, 220: number of sprite words scanned per pass (addresses 0..SPRITE_WORDS-1).
- SCREEN_W, 160: horizontal limit; pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 120: vertical limit; pixels with y >= SCREEN_H are suppressed.
- BG_COLOUR, 3'b000: colour written during the erase pass.

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  synchronous active-low reset.
- start  in  1  request a redraw at x_coord/y_coord; sampled only in IDLE.
- x_coord  in  8  new sprite origin, x.
- y_coord  in  7  new sprite origin, y.
- word_addr  out  10  sprite word address, drives the async-read word store.
- word_in  in  16  sprite word returned combinationally for word_addr.
- x  out  8  pixel x to the VGA adapter.
- y  out  7  pixel y to the VGA adapter.
- colour  out  3  pixel colour.
- writeEn  out  1  pixel write strobe.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a redraw completes.

Behaviour:
- Reset is synchronous, active-low (resetn=0 sampled on the clock edge).
- Reset values: state=IDLE, word_addr=0, x=0, y=0, colour=0, writeEn=0, busy=0, done=0, have_old=0, old origin=0.
- Word format:
  - [15:11] x offset, 0..31.
  - [10:6] y offset, 0..31.
  - [5:3] colour.
  - [2:1] reserved, ignored.
  - [0] valid. Words with valid=0 never produce writeEn.
- States: IDLE, ERASE, DRAW, FLUSH, DONE.
- IDLE:
  - On start=1: latch new origin (nx, ny) and set word_addr=0.
  - If have_old=1, go to ERASE; otherwise go to DRAW.
  - start while busy is ignored.
- ERASE / DRAW:
  - Each cycle presents word_addr, registers that word's pixel, and increments word_addr.
  - When word_addr = SPRITE_WORDS-1: ERASE goes to DRAW with word_addr=0; DRAW goes to FLUSH.
- Output pipeline: 1-cycle latency. Signals registered on edge k describe the word at word_addr during cycle k.
  - ERASE pass: x = old_x + xoff, y = old_y + yoff, colour = BG_COLOUR.
  - DRAW pass: x = nx + xoff, y = ny + yoff, colour = word colour.
- Arithmetic:
  - Sums are computed at 9 bits (x) and 8 bits (y) before truncation, so no wrap-around.
  - writeEn = valid AND sum_x < SCREEN_W AND sum_y < SCREEN_H.
  - When writeEn=0, x/y/colour still carry the truncated values; the consumer ignores them.
- FLUSH: emits the last DRAW pixel; no new address is consumed.
- DONE:
  - writeEn=0, done=1 for one cycle.
  - Old origin <= (nx, ny); have_old <= 1; then IDLE.
- Cycle counts from the start edge:
  - First redraw after reset: SPRITE_WORDS+2 cycles until done.
  - Later redraws: 2*SPRITE_WORDS+2 cycles until done.
- Boundary cases:
  - Origin (159,119): only offset (0,0) can write.
  - start and done in the same cycle: start is ignored (the FSM is not yet in IDLE).
  - start held high: a new redraw begins the cycle after return to IDLE.
  - resetn low mid-pass: immediate return to reset values. have_old is cleared, so the next redraw skips ERASE.
- busy is high from the cycle after start is accepted through the DONE cycle inclusive.

Optional Feature:
- Macro: SPRITE_TRANSPARENCY_EN.
- Defined:
  - Words with colour 3'b111 are transparent and treated as valid=0 in both passes (neither drawn nor erased).
  - Cycle counts are unchanged.
- Undefined: 3'b111 is an ordinary colour (white) and is drawn and erased normally.

Test Plan:
- Reset then start at (10,20) with word 5 = {xoff=3, yoff=4, col=3'b100, valid=1} and all other words invalid.
  - Exactly one writeEn pulse: x=13, y=24, colour=4.
  - done arrives 222 cycles after the start edge.
- Second start at (50,60) with the same memory.
  - Erase write at (13,24) with colour 0, then draw write at (53,64) with colour 4.
  - done arrives 442 cycles after start.
- Start at (150,110) with a word at offset (12,12).
  - No writeEn (x sum 162 >= 160).
  - A word at offset (9,9) writes (159,119).
- Pulse start again while busy.
  - No effect on state, address sequence, or done timing.
- Assert resetn low mid-DRAW (word_addr=100).
  - Next edge: all outputs 0, busy=0.
  - A following start skips ERASE.
- With SPRITE_TRANSPARENCY_EN defined, load a valid word with colour 3'b111.
  - No writeEn in either pass.
  - Without the macro, that word writes colour 7.
